// File: rtl/game_pkg.sv
// Shared game encodings: game states, sprite directions, button indices and player FSM states.
package game_pkg;

  typedef enum logic [3:0] {
    GsTitle    = 4'd0,
    GsStaff    = 4'd1,
    GsStage1   = 4'd2,
    GsSuccess1 = 4'd3,
    GsStage2   = 4'd4,
    GsSuccess2 = 4'd5,
    GsStage3   = 4'd6,
    GsSuccess3 = 4'd7,
    GsFail     = 4'd8
  } game_state_e;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;

  localparam int unsigned SPRITE_W = 10;
  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;

  typedef enum logic [1:0] {
    StHold,
    StSpawn,
    StIdle,
    StWalk
  } player_fsm_e;

  function automatic logic is_stage(input logic [3:0] s);
    return (s == GsStage1) || (s == GsStage2) || (s == GsStage3);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running 0..DIV-1 divider that pulses tick_o for one cycle at DIV-1; clr_i restarts it.
module tick_gen #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax) && !clr_i;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Player sprite position/animation and title-menu cursor controller.
// Define PLAYER_DIAG_EN to allow one vertical plus one horizontal step per move tick.
module player_ctrl
  import game_pkg::*;
#(
  parameter int unsigned MOVE_DIV = 1_000_000,
  parameter int unsigned ANIM_DIV = 10_000_000,
  parameter int unsigned X_MAX    = SCREEN_W - SPRITE_W,
  parameter int unsigned Y_MAX    = SCREEN_H - SPRITE_W,
  parameter int unsigned START_X  = 20,
  parameter int unsigned START_Y  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic [3:0] btn,
  input  logic [3:0] blocked,
  output logic [8:0] player_x,
  output logic [8:0] player_y,
  output logic [3:0] player_state,
  output logic [3:0] play_valid
);

  localparam logic [8:0] XMax   = 9'(X_MAX);
  localparam logic [8:0] YMax   = 9'(Y_MAX);
  localparam logic [8:0] StartX = 9'(START_X);
  localparam logic [8:0] StartY = 9'(START_Y);

  player_fsm_e fsm_q, fsm_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  dir_q, dir_d, frame_q, frame_d;
  logic [3:0]  cursor_q, cursor_d;
  logic [3:0]  state_q;
  logic [1:0]  btn_q;
  logic        move_tick, anim_tick, state_chg, in_stage;
  logic        up_ok, dn_ok, lt_ok, rt_ok, up_edge, dn_edge;
  logic [1:0]  walk_dir;
  logic [8:0]  x_step, y_step;

  assign state_chg = (state != state_q);
  assign in_stage  = is_stage(state);

  tick_gen #(.DIV(MOVE_DIV)) u_move_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_chg),
    .tick_o (move_tick)
  );

  tick_gen #(.DIV(ANIM_DIV)) u_anim_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (1'b0),
    .tick_o (anim_tick)
  );

  assign up_ok = !blocked[BTN_UP] && (y_q != 9'd0);
  assign dn_ok = !blocked[BTN_DOWN] && (y_q < YMax);
  assign lt_ok = !blocked[BTN_LEFT] && (x_q != 9'd0);
  assign rt_ok = !blocked[BTN_RIGHT] && (x_q < XMax);

  // Candidate direction and position for a move tick in WALK.
  always_comb begin
    walk_dir = DIR_DOWN;
    x_step   = x_q;
    y_step   = y_q;
`ifdef PLAYER_DIAG_EN
    if (btn[BTN_UP]) begin
      walk_dir = DIR_UP;
      if (up_ok) y_step = y_q - 9'd1;
    end else if (btn[BTN_DOWN]) begin
      walk_dir = DIR_DOWN;
      if (dn_ok) y_step = y_q + 9'd1;
    end
    if (btn[BTN_LEFT]) begin
      if (!btn[BTN_UP] && !btn[BTN_DOWN]) walk_dir = DIR_LEFT;
      if (lt_ok) x_step = x_q - 9'd1;
    end else if (btn[BTN_RIGHT]) begin
      if (!btn[BTN_UP] && !btn[BTN_DOWN]) walk_dir = DIR_RIGHT;
      if (rt_ok) x_step = x_q + 9'd1;
    end
`else
    if (btn[BTN_UP]) begin
      walk_dir = DIR_UP;
      if (up_ok) y_step = y_q - 9'd1;
    end else if (btn[BTN_DOWN]) begin
      walk_dir = DIR_DOWN;
      if (dn_ok) y_step = y_q + 9'd1;
    end else if (btn[BTN_LEFT]) begin
      walk_dir = DIR_LEFT;
      if (lt_ok) x_step = x_q - 9'd1;
    end else if (btn[BTN_RIGHT]) begin
      walk_dir = DIR_RIGHT;
      if (rt_ok) x_step = x_q + 9'd1;
    end
`endif
  end

  assign up_edge = btn[BTN_UP] && !btn_q[BTN_UP];
  assign dn_edge = btn[BTN_DOWN] && !btn_q[BTN_DOWN];

  always_comb begin
    fsm_d    = fsm_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    frame_d  = frame_q;
    cursor_d = cursor_q;

    unique case (fsm_q)
      StHold: begin
        if (anim_tick) frame_d = frame_q + 2'd1;
        if (in_stage) fsm_d = StSpawn;
      end
      StSpawn: begin
        x_d     = StartX;
        y_d     = StartY;
        dir_d   = DIR_DOWN;
        frame_d = 2'd0;
        fsm_d   = in_stage ? StIdle : StHold;
      end
      StIdle: begin
        frame_d = 2'd0;
        if (!in_stage)       fsm_d = StHold;
        else if (state_chg)  fsm_d = StSpawn;
        else if (btn != '0)  fsm_d = StWalk;
      end
      StWalk: begin
        if (!in_stage) begin
          fsm_d = StHold;
        end else if (state_chg) begin
          fsm_d = StSpawn;
        end else if (btn == '0) begin
          fsm_d   = StIdle;
          frame_d = 2'd0;
        end else begin
          dir_d = walk_dir;
          if (move_tick) begin
            x_d = x_step;
            y_d = y_step;
          end
          if (anim_tick) frame_d = frame_q + 2'd1;
        end
      end
      default: fsm_d = StHold;
    endcase

    // Cursor rotates over bits [3:1]; opposing edges in the same cycle cancel.
    if (state == GsTitle) begin
      if (up_edge && !dn_edge) begin
        cursor_d = {cursor_q[1], cursor_q[3], cursor_q[2], 1'b0};
      end else if (dn_edge && !up_edge) begin
        cursor_d = {cursor_q[2], cursor_q[1], cursor_q[3], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= StHold;
      x_q      <= StartX;
      y_q      <= StartY;
      dir_q    <= DIR_DOWN;
      frame_q  <= 2'd0;
      cursor_q <= 4'b0010;
      state_q  <= 4'd0;
      btn_q    <= 2'b00;
    end else begin
      fsm_q    <= fsm_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      frame_q  <= frame_d;
      cursor_q <= cursor_d;
      state_q  <= state;
      btn_q    <= btn[1:0];
    end
  end

  assign player_x     = x_q;
  assign player_y     = y_q;
  assign player_state = {dir_q, frame_q};
  assign play_valid   = cursor_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: reset, animation, title cursor table, walking and bounds.
module tb_player_ctrl;
  import game_pkg::*;

  localparam int unsigned MoveDiv = 4;
  localparam int unsigned AnimDiv = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = 4'd0;
  logic [3:0] btn = 4'd0;
  logic [3:0] blocked = 4'd0;
  logic [8:0] player_x, player_y;
  logic [3:0] player_state, play_valid;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] exp_pv;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  player_ctrl #(
    .MOVE_DIV (MoveDiv),
    .ANIM_DIV (AnimDiv)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .state        (state),
    .btn          (btn),
    .blocked      (blocked),
    .player_x     (player_x),
    .player_y     (player_y),
    .player_state (player_state),
    .play_valid   (play_valid)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_frame(output int cyc, output bit ok);
    logic [1:0] f;
    f   = player_state[1:0];
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 4 * AnimDiv && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (player_state[1:0] != f) ok = 1'b1;
    end
  endtask

  task automatic wait_pos(output int cyc, output bit ok);
    logic [8:0] x0, y0;
    x0  = player_x;
    y0  = player_y;
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 4 * MoveDiv && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (player_x != x0 || player_y != y0) ok = 1'b1;
    end
  endtask

  task automatic walk_until_x(input int target, input int limit);
    for (int i = 0; i < limit && int'(player_x) != target; i++) @(negedge clk);
    chk("reach_x", int'(player_x), target);
  endtask

  initial begin
    int  cyc;
    bit  ok;
    int  prev;

    vecs[0]  = '{4'b0001, 4'b1000};
    vecs[1]  = '{4'b0000, 4'b1000};
    vecs[2]  = '{4'b0010, 4'b0010};
    vecs[3]  = '{4'b0000, 4'b0010};
    vecs[4]  = '{4'b0010, 4'b0100};
    vecs[5]  = '{4'b0000, 4'b0100};
    vecs[6]  = '{4'b0011, 4'b0100};
    vecs[7]  = '{4'b0000, 4'b0100};
    vecs[8]  = '{4'b0001, 4'b0010};
    vecs[9]  = '{4'b0001, 4'b0010};
    vecs[10] = '{4'b0000, 4'b0010};
    vecs[11] = '{4'b0001, 4'b1000};

    repeat (2) @(negedge clk);
    chk("rst_x", int'(player_x), 20);
    chk("rst_y", int'(player_y), 20);
    chk("rst_pstate", int'(player_state), 0);
    chk("rst_pvalid", int'(play_valid), 2);
    rst_n = 1'b1;

    // Animation frame in HOLD: steady cadence and 3->0 wrap.
    wait_frame(cyc, ok);
    chk("hold_frame_first", int'(ok), 1);
    for (int k = 0; k < 4; k++) begin
      prev = int'(player_state[1:0]);
      wait_frame(cyc, ok);
      chk("hold_frame_seen", int'(ok), 1);
      chk("hold_frame_period", cyc, AnimDiv);
      chk("hold_frame_value", int'(player_state[1:0]), (prev + 1) % 4);
    end

    for (int i = 0; i < 12; i++) begin
      btn = vecs[i].btn;
      @(negedge clk);
      chk($sformatf("cursor[%0d]", i), int'(play_valid), int'(vecs[i].exp_pv));
    end
    btn = 4'b0000;
    @(negedge clk);

    state = 4'(GsStage1);
    repeat (2) @(negedge clk);
    chk("spawn_x", int'(player_x), 20);
    chk("spawn_y", int'(player_y), 20);
    chk("spawn_pstate", int'(player_state), 0);

    btn = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      wait_pos(cyc, ok);
      chk("up_step_seen", int'(ok), 1);
      chk("up_y", int'(player_y), 20 - i);
      chk("up_x", int'(player_x), 20);
      if (i > 1) chk("up_period", cyc, MoveDiv);
    end
    chk("up_dir", int'(player_state[3:2]), 1);
    btn = 4'b0000;
    repeat (2) @(negedge clk);

    btn = 4'b1000;
    walk_until_x(310, 300 * MoveDiv + 40);
    repeat (3 * MoveDiv) @(negedge clk);
    chk("right_bound_x", int'(player_x), 310);
    chk("right_bound_y", int'(player_y), 15);
    chk("right_dir", int'(player_state[3:2]), 3);

    btn = 4'b0100;
    walk_until_x(0, 320 * MoveDiv + 40);
    repeat (3 * MoveDiv) @(negedge clk);
    chk("left_bound_x", int'(player_x), 0);
    chk("left_dir", int'(player_state[3:2]), 2);
    btn = 4'b0000;
    repeat (2) @(negedge clk);

    blocked = 4'b0010;
    btn     = 4'b0010;
    repeat (3 * MoveDiv) @(negedge clk);
    chk("blocked_y", int'(player_y), 15);
    chk("blocked_x", int'(player_x), 0);
    chk("blocked_dir", int'(player_state[3:2]), 0);
    btn = 4'b0011;
    wait_pos(cyc, ok);
    chk("prio_step_seen", int'(ok), 1);
    chk("prio_y", int'(player_y), 14);
    chk("prio_dir", int'(player_state[3:2]), 1);
    btn     = 4'b0000;
    blocked = 4'b0000;
    repeat (2) @(negedge clk);

    state = 4'(GsStage2);
    repeat (3) @(negedge clk);
    chk("respawn_x", int'(player_x), 20);
    chk("respawn_y", int'(player_y), 20);
    chk("respawn_pstate", int'(player_state), 0);

    btn = 4'b1000;
    walk_until_x(57, 60 * MoveDiv + 40);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_x", int'(player_x), 20);
    chk("async_rst_y", int'(player_y), 20);
    chk("async_rst_pstate", int'(player_state), 0);
    chk("async_rst_pvalid", int'(play_valid), 2);
    @(negedge clk);
    btn   = 4'b0000;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_x", int'(player_x), 20);
    chk("post_rst_dir", int'(player_state[3:2]), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Sequential producer of the player sprite's position, animation index and title-menu cursor, consumed by the player sprite address generator.
- Converts button levels/edges and per-direction collision flags into registered player_x, player_y, player_state and play_valid.
- Works in 320x240 half-resolution coordinates with a 10x10 sprite.
- Sits between the input debouncers/collision map and the draw path.

Parameters:
MOVE_DIV, 1_000_000, clk cycles per movement step (100 px/s at 100 MHz)
ANIM_DIV, 10_000_000, clk cycles per animation frame advance
X_MAX, 310, largest legal player_x (320 - sprite width)
Y_MAX, 230, largest legal player_y (240 - sprite height)
START_X, 20, spawn x for every stage
START_Y, 20, spawn y for every stage

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
state  in  4  game state (TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8)
btn  in  4  debounced button levels {right,left,down,up} = [3:0]
blocked  in  4  collision flags for a step in each direction; same bit order as btn
player_x  out  9  sprite left edge
player_y  out  9  sprite top edge
player_state  out  4  {dir[1:0], frame[1:0]}; dir: 0=down, 1=up, 2=left, 3=right
play_valid  out  4  one-hot title cursor over bits [3:1]; bit0 is always 0

Behaviour:
- Reset is asynchronous, active-low, with a single clock clk.
- Reset values:
  - player_x=START_X, player_y=START_Y.
  - player_state=0.
  - play_valid=4'b0010.
  - FSM=HOLD.
  - Both tick counters=0.
- All outputs are registered.
- Tick generators:
  - Each is a free-running counter 0..DIV-1 that pulses for 1 cycle at DIV-1 and then wraps to 0.
  - The move tick is cleared on every state change.
- FSM states:
  - HOLD:
    - Active while state is not STAGE1/2/3.
    - Position frozen.
    - Frame advances on the anim tick, wrapping 3->0. This drives the menu and result screens.
    - Goes to SPAWN when state enters a STAGE value.
  - SPAWN:
    - Lasts exactly 1 cycle.
    - Loads START_X/START_Y, dir=down, frame=0.
    - Then goes to IDLE.
    - Also entered on any direct change between two STAGE values.
  - IDLE:
    - frame=0.
    - Goes to WALK when any btn bit is 1.
  - WALK:
    - Selects the highest-priority pressed direction: up > down > left > right. dir updates immediately to that direction.
    - On each move tick, position changes by ±1 toward dir unless blocked[dir]=1 or the move would leave [0,X_MAX]x[0,Y_MAX]. A refused move leaves the position unchanged, but dir still updates.
    - Frame advances on the anim tick.
    - Returns to IDLE when btn==0; frame resets to 0 on that transition.
  - From IDLE or WALK: goes to HOLD when state leaves the STAGE set.
- Position latency: the new position is visible on player_x/y 1 cycle after the move tick.
- Title cursor:
  - Active only when state==TITLE.
  - A rising edge of btn[0] (up) shifts the cursor toward bit1; a rising edge of btn[1] (down) shifts it toward bit3.
  - Both directions wrap: 0010 -> up -> 1000, and 1000 -> down -> 0010.
  - Simultaneous up and down edges: no change.
  - Edge detection uses a 1-cycle registered copy of btn.
  - Outside TITLE the cursor holds its value.
- Reset asserted mid-walk: all outputs return immediately to their reset values. Operation resumes from HOLD after release.

Optional Feature:
- PLAYER_DIAG_EN defined:
  - In WALK, one vertical and one horizontal button may act together. The vertical direction takes up > down priority; the horizontal takes left > right.
  - Each axis is gated independently by its blocked flag and bounds.
  - Both axes step on the same move tick.
  - dir shows the vertical direction.
- Undefined: single-axis priority movement only, as described above.

Decomposition:
- game_pkg holds:
  - game state encodings (TITLE..FAIL).
  - direction codes DIR_DOWN/UP/LEFT/RIGHT and btn bit indices.
  - SPRITE_W=10, SCREEN_W=320, SCREEN_H=240.
  - FSM state enum (HOLD/SPAWN/IDLE/WALK).
- One sub-module, tick_gen: parameterised divider with a synchronous clear input, instantiated twice (move and anim).

Test Plan:
- Reset, then state=STAGE1 -> 1 cycle later player_x=20, player_y=20, player_state=0; FSM passes through SPAWN to IDLE.
- STAGE1, MOVE_DIV=4, btn=0001 held for 5 move ticks -> player_y goes 20->15 one cycle after each tick; player_state[3:2]=1.
- player_x=310, btn=1000 held -> player_x stays 310 and dir=3; repeat at x=0 with btn=0100 -> x stays 0.
- blocked=0010 with btn=0010 -> position unchanged; btn=0011 -> up wins and y decrements.
- TITLE, play_valid=0010; up edge -> 1000; down edge -> 0010; down edge -> 0100; up and down edges in the same cycle -> unchanged.
- rst_n pulsed low mid-walk at x=57 -> x=20, y=20, player_state=0 and play_valid=0010 asynchronously, before the next clk edge.
